// File: rtl/stack_stream_reverser.sv
// Stack client that reverses each framed input stream: pushes words into a LIFO,
// then on end-of-frame (or stack full) pops them back out as an output stream.
//
// state   | meaning
// FILL    | accept input words and push them onto the stack
// POP     | one-cycle pop to preload the first output word
// PRESENT | offer stack output; pop the next word on each handshake
module stack_stream_reverser #(
  parameter int WL    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WL-1:0]              s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WL-1:0]              m_data,
  output logic                       m_last,
  output logic                       wReq,
  output logic                       rReq,
  output logic [WL-1:0]              stk_din,
  input  logic [WL-1:0]              stk_dout,
  input  logic                       Full,
  input  logic                       Empty,
  input  logic                       Error,
  output logic [$clog2(DEPTH+1)-1:0] frame_len,
  output logic                       trunc,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    POP     = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] frame_len_q, frame_len_d;
  logic          trunc_q, trunc_d;
  logic          err_q, err_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= FILL;
      count_q     <= '0;
      frame_len_q <= '0;
      trunc_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_len_q <= frame_len_d;
      trunc_q     <= trunc_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_len_d = frame_len_q;
    trunc_d     = trunc_q;
    err_d       = err_q | Error;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    wReq        = 1'b0;
    rReq        = 1'b0;
    case (state_q)
      FILL: begin
        s_ready = ~Full;
        // A full stack closes the frame; the pending input word starts the next one.
        if (Full) begin
          state_d = POP;
          trunc_d = 1'b1;
        end else if (s_valid) begin
          wReq    = 1'b1;
          count_d = count_q + CW'(1);
          if (s_last) state_d = POP;
        end
      end
      POP: begin
        rReq        = 1'b1;
        frame_len_d = count_q;
        count_d     = '0;
        state_d     = PRESENT;
      end
      PRESENT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (Empty) state_d = FILL;
          else       rReq    = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // The stack holds dout between pops, so the output stays stable while stalled.
  assign m_data    = stk_dout;
  assign m_last    = Empty;
  assign stk_din   = s_data;
  assign frame_len = frame_len_q;
  assign trunc     = trunc_q;
  assign err       = err_q;

endmodule

// File: doc/stack_stream_reverser.md
# stack_stream_reverser

Stack client that drives the push/pop side of the team's LIFO stack. It accepts a framed input stream (valid/ready/last), pushes each word, and on end-of-frame pops the stack back out as an output stream, so every frame leaves in reverse order. It sits between a producer and consumer, with the stack instance on the same clock.

## Interface
Parameters:
- WL, 8, data word width; must equal the stack's WL.
- DEPTH, 16, stack capacity in words; must equal the stack's DEPTH.

Ports:
- CLK  in  1  clock shared with the stack.
- RST  in  1  asynchronous, active-high reset. The stack's active-low synchronous reset is driven from ~RST.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  WL  input word.
- s_last  in  1  final word of input frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts when m_valid & m_ready.
- m_data  out  WL  output word.
- m_last  out  1  final word of output frame.
- wReq  out  1  push request to stack.
- rReq  out  1  pop request to stack.
- stk_din  out  WL  push data to stack.
- stk_dout  in  WL  stack pop data, registered by the stack one cycle after rReq.
- Full  in  1  stack full.
- Empty  in  1  stack empty.
- Error  in  1  stack error (push on full or pop on empty).
- frame_len  out  $clog2(DEPTH+1)  word count of the most recent frame, latched on entry to POP.
- trunc  out  1  sticky: a frame was cut at DEPTH words.
- err  out  1  sticky: the stack's Error was sampled high.

## Operation
- FSM states: FILL (reset state), POP, PRESENT.
- FILL:
  - s_ready = ~Full.
  - On accept: wReq=1, stk_din=s_data, and the count increments.
  - Accepted word with s_last=1: go to POP.
  - Full=1: go to POP and set trunc. No word is accepted that cycle. Remaining input words form the next frame.
- POP:
  - rReq=1 for exactly one cycle; s_ready=0.
  - Latch frame_len = count, clear count.
  - Go to PRESENT.
- PRESENT:
  - m_valid=1, m_data=stk_dout (combinational passthrough; the stack holds dout between pops).
  - m_last=Empty.
  - On handshake with Empty=0: rReq=1 and stay in PRESENT. New data appears the next cycle.
  - On handshake with Empty=1: go to FILL.
  - With no handshake, m_data/m_last are held stable.
- wReq and rReq are never high in the same cycle. wReq is only asserted in FILL; rReq only in POP/PRESENT.
- err sets when Error=1 in any cycle. trunc and err clear only on RST.
- Count width is $clog2(DEPTH+1); it never exceeds DEPTH.

## Timing
- Reset values: s_ready=1 (once the stack is out of reset, Full=0), m_valid=0, m_data=stk_dout, m_last=Empty, wReq=0, rReq=0, stk_din=s_data, frame_len=0, trunc=0, err=0, state FILL.
- Last input word accepted in cycle t:
  - POP (rReq) in t+1.
  - First output word valid in t+2.
- With m_ready held high: one output word per cycle. A frame of N words drains in N cycles after t+1.
- Input throughput in FILL: one word per cycle.
- Turnaround: FILL is re-entered the cycle after the last output handshake. The next s_ready is then 1.
- RST asserted mid-frame: all state is cleared immediately (async). The stack is emptied via its own reset. The partial frame is discarded and not emitted.

## Test plan
- Frame 0x11,0x22,0x33 (last on 0x33), m_ready=1 -> m_data 0x33,0x22,0x11; m_last only on 0x11; first m_valid 2 cycles after last accept; frame_len=3.
- Single-word frame 0xA5 -> one output 0xA5 with m_last=1; FSM returns to FILL; s_ready=1 the cycle after the handshake.
- DEPTH=16 frame of 20 words 0..19 -> s_ready drops at Full; output 15..0 with m_last on 0; trunc=1; frame_len=16; words 16..19 then emerge as the next frame 19..16.
- Output backpressure: m_ready toggling 1,0,0,1,… during drain -> m_data/m_last stable while stalled; no rReq in stalled cycles; order preserved; no word lost or duplicated.
- Back-to-back frames {1,2} then {3,4,5}, with s_valid held high -> output 2,1 then 5,4,3; s_ready=0 throughout POP/PRESENT; err stays 0.
- RST pulsed after 5 of 8 words pushed -> all outputs at reset values; the next frame {7,8} outputs 8,7 with no stale data.
